// File: rtl/relu_maxpool2x2_stream.sv
// rtl/relu_maxpool2x2_stream.sv - per-channel ReLU followed by 2x2 stride-2 max-pool on a raster stream
module relu_maxpool2x2_stream #(
    parameter int IN_W  = 24,
    parameter int IN_H  = 24,
    parameter int DW    = 15,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             frame_start,
    input  logic [DW-1:0]    conv_in_1,
    input  logic [DW-1:0]    conv_in_2,
    input  logic [DW-1:0]    conv_in_3,
    output logic [DW-1:0]    pool_out_1,
    output logic [DW-1:0]    pool_out_2,
    output logic [DW-1:0]    pool_out_3,
    output logic [IDX_W-1:0] pool_idx,
    output logic             valid_out,
    output logic             frame_done
);
    localparam int CW       = $clog2(IN_W);
    localparam int RW       = $clog2(IN_H);
    localparam int HALF_W   = IN_W / 2;
    localparam int LAST_IDX = (IN_W / 2) * (IN_H / 2) - 1;

    logic [CW-1:0]    col_cnt, cur_col;
    logic [RW-1:0]    row_cnt, cur_row;
    logic [CW-2:0]    hcol;
    logic [IDX_W-1:0] idx_calc;
    logic             fire;

    logic [DW-1:0] x      [3];
    logic [DW-1:0] r      [3];
    logic [DW-1:0] h      [3];
    logic [DW-1:0] v      [3];
    logic [DW-1:0] h_hold [3];
    logic [DW-1:0] line_buf [3][HALF_W];

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // frame_start realigns the sample on the same cycle, so it is treated as pixel (0,0)
    assign cur_col  = frame_start ? '0 : col_cnt;
    assign cur_row  = frame_start ? '0 : row_cnt;
    assign hcol     = cur_col[CW-1:1];
    assign fire     = valid_in && cur_row[0] && cur_col[0];
    assign idx_calc = IDX_W'(cur_row[RW-1:1]) * IDX_W'(HALF_W) + IDX_W'(hcol);

    assign x[0] = conv_in_1;
    assign x[1] = conv_in_2;
    assign x[2] = conv_in_3;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            r[i] = x[i][DW-1] ? '0 : x[i];
            h[i] = smax(h_hold[i], r[i]);
            v[i] = smax(line_buf[i][hcol], h[i]);
        end
    end

    // Datapath storage is fully overwritten each window before use, so it carries no reset
    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int i = 0; i < 3; i++) begin
                if (!cur_col[0])
                    h_hold[i] <= r[i];
                else if (!cur_row[0])
                    line_buf[i][hcol] <= h[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (valid_in) begin
            if (cur_col == CW'(IN_W - 1)) begin
                col_cnt <= '0;
                row_cnt <= (cur_row == RW'(IN_H - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_cnt <= cur_col + 1'b1;
                row_cnt <= cur_row;
            end
        end else if (frame_start) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pool_out_1 <= '0;
            pool_out_2 <= '0;
            pool_out_3 <= '0;
            pool_idx   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= fire;
            frame_done <= fire && (idx_calc == IDX_W'(LAST_IDX));
            if (fire) begin
                pool_out_1 <= v[0];
                pool_out_2 <= v[1];
                pool_out_3 <= v[2];
                pool_idx   <= idx_calc;
            end
        end
    end
endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
// tb/tb_relu_maxpool2x2_stream.sv - directed self-checking bench for relu_maxpool2x2_stream
module tb_relu_maxpool2x2_stream;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        frame_start;
    logic [14:0] conv_in_1, conv_in_2, conv_in_3;
    logic [14:0] pool_out_1, pool_out_2, pool_out_3;
    logic [7:0]  pool_idx;
    logic        valid_out;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    int mode, trow, tcol;
    int obs_pulses, exp_pulses, accepted, first_pulse_at;
    int last1, last2, last3, last_idx;

    relu_maxpool2x2_stream #(.IN_W(24), .IN_H(24), .DW(15), .IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .frame_start(frame_start),
        .conv_in_1(conv_in_1), .conv_in_2(conv_in_2), .conv_in_3(conv_in_3),
        .pool_out_1(pool_out_1), .pool_out_2(pool_out_2), .pool_out_3(pool_out_3),
        .pool_idx(pool_idx), .valid_out(valid_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic int relu(input int a);
        return (a < 0) ? 0 : a;
    endfunction

    // Test frames: mode 0 ramp, mode 1 all -100, mode 2 ramp with the extremes window at (0,0)
    function automatic int pix(input int ch, input int r, input int c);
        int base, k;
        base = r * 24 + c;
        k = r * 2 + c;
        if (mode == 1) return -100;
        if (mode == 2 && r < 2 && c < 2) begin
            if (ch == 0) return (k == 0) ? 16383 : (k == 1) ? -16384 : (k == 2) ? 5 : 0;
            if (ch == 1) return -1;
            return (k == 0) ? 3 : (k == 3) ? 2 : 7;
        end
        if (ch == 0) return base;
        if (ch == 1) return 600 - base;
        return base - 300;
    endfunction

    function automatic int exp_pool(input int ch, input int pr, input int pc);
        int m;
        m = 0;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if (relu(pix(ch, 2 * pr + dr, 2 * pc + dc)) > m)
                    m = relu(pix(ch, 2 * pr + dr, 2 * pc + dc));
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input bit fs);
        int r, c, eidx;
        bit ev;
        if (fs) begin
            trow = 0;
            tcol = 0;
        end
        r = trow;
        c = tcol;
        valid_in = v;
        frame_start = fs;
        if (v) begin
            conv_in_1 = 15'(pix(0, r, c));
            conv_in_2 = 15'(pix(1, r, c));
            conv_in_3 = 15'(pix(2, r, c));
        end else begin
            conv_in_1 = 15'($urandom);
            conv_in_2 = 15'($urandom);
            conv_in_3 = 15'($urandom);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        frame_start = 1'b0;
        ev = v && (r % 2 == 1) && (c % 2 == 1);
        if (v) begin
            accepted++;
            tcol++;
            if (tcol == 24) begin
                tcol = 0;
                trow = (trow == 23) ? 0 : trow + 1;
            end
        end
        if (valid_out) obs_pulses++;
        chk("valid_out", 32'(valid_out), 32'(ev));
        if (ev) begin
            eidx = (r / 2) * 12 + c / 2;
            last1 = exp_pool(0, r / 2, c / 2);
            last2 = exp_pool(1, r / 2, c / 2);
            last3 = exp_pool(2, r / 2, c / 2);
            last_idx = eidx;
            chk("pool_out_1", 32'(pool_out_1), last1);
            chk("pool_out_2", 32'(pool_out_2), last2);
            chk("pool_out_3", 32'(pool_out_3), last3);
            chk("pool_idx", 32'(pool_idx), eidx);
            chk("frame_done", 32'(frame_done), 32'(eidx == 143));
            exp_pulses++;
            if (first_pulse_at < 0) first_pulse_at = accepted;
        end else begin
            chk("frame_done_idle", 32'(frame_done), 0);
            chk("hold_out_1", 32'(pool_out_1), last1);
            chk("hold_out_3", 32'(pool_out_3), last3);
            chk("hold_idx", 32'(pool_idx), last_idx);
        end
    endtask

    task automatic run_frame(input int m, input bit gaps, input int n, input bit fs0);
        mode = m;
        obs_pulses = 0;
        exp_pulses = 0;
        for (int k = 0; k < n; k++) begin
            if (gaps)
                while ($urandom_range(0, 1) == 0) step(1'b0, 1'b0);
            step(1'b1, fs0 && (k == 0));
        end
    endtask

    task automatic model_reset();
        trow = 0; tcol = 0;
        last1 = 0; last2 = 0; last3 = 0; last_idx = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0;
        frame_start = 1'b0;
        conv_in_1 = '0; conv_in_2 = '0; conv_in_3 = '0;
        model_reset();
        accepted = 0;
        first_pulse_at = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", 32'(valid_out), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_pool_out_1", 32'(pool_out_1), 0);
        chk("rst_pool_out_2", 32'(pool_out_2), 0);
        chk("rst_pool_out_3", 32'(pool_out_3), 0);
        chk("rst_pool_idx", 32'(pool_idx), 0);
        rst_n = 1'b1;

        run_frame(0, 1'b0, 576, 1'b0);
        chk("ramp_pulses", obs_pulses, 144);
        chk("first_pulse_sample", first_pulse_at, 26);

        run_frame(1, 1'b0, 576, 1'b0);
        chk("neg_pulses", obs_pulses, 144);

        run_frame(2, 1'b0, 576, 1'b0);
        chk("ext_pulses", obs_pulses, 144);

        run_frame(0, 1'b1, 576, 1'b0);
        chk("gap_pulses", obs_pulses, 144);

        run_frame(0, 1'b0, 100, 1'b0);
        run_frame(0, 1'b0, 576, 1'b1);
        chk("fs_pulses", obs_pulses, 144);

        run_frame(0, 1'b0, 37, 1'b0);
        step(1'b0, 1'b1);
        run_frame(0, 1'b0, 576, 1'b0);
        chk("fs_idle_pulses", obs_pulses, 144);

        run_frame(0, 1'b0, 50, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_pool_out_1", 32'(pool_out_1), 0);
        chk("midrst_pool_idx", 32'(pool_idx), 0);
        chk("midrst_valid_out", 32'(valid_out), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run_frame(0, 1'b0, 576, 1'b0);
        chk("midrst_pulses", obs_pulses, 144);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
